// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch/prefetch unit.
package fetch_prefetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0021_0824;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: registered storage, first-word-fall-through head, synchronous flush.
module fetch_queue #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == CNT_W'(0));
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full_s || do_pop_s);
    assign rdata     = storage_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage; stale contents are harmless because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            storage_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: program memory, PC, LOAD/RUN/HALTED control and a prefetch queue.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int RAM_WIDTH_PROGRAMA = 32,
    parameter int CANT_BITS_ADDR     = 11,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_load_en,
    input  logic [CANT_BITS_ADDR-1:0]     i_load_addr,
    input  logic [RAM_WIDTH_PROGRAMA-1:0] i_load_data,
    input  logic                          i_start,
    input  logic                          i_stall,
    input  logic                          i_branch_valid,
    input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
    output logic [RAM_WIDTH_PROGRAMA-1:0] o_instruction,
    output logic                          o_valid,
    output logic [CANT_BITS_ADDR-1:0]     o_direccion_adder_pc,
    output logic [CANT_BITS_ADDR-1:0]     o_contador_programa,
    output logic                          o_halted,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int W         = RAM_WIDTH_PROGRAMA;
    localparam int A         = CANT_BITS_ADDR;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int MEM_DEPTH = 2 ** A;
    localparam int ENTRY_W   = W + A;
    localparam logic [W-1:0] NOP_WORD  = W'(NOP_INSTR);
    localparam logic [W-1:0] HALT_WORD = W'(HALT_INSTR);

    fetch_state_e       state_r, state_nxt_s;
    logic [A-1:0]       pc_r, pc_nxt_s, rd_addr_s, rd_pc1_r;
    logic [W-1:0]       mem_r [MEM_DEPTH];
    logic [W-1:0]       rd_data_r;
    logic               inflight_r;
    logic               issue_s, push_s, pop_s, flush_s;
    logic [ENTRY_W-1:0] head_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W:0]     occ_s;
    logic               empty_s;

    assign occ_s = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r};

    // Next-state, read issue and queue control; a redirect fetches its target in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        rd_addr_s   = pc_r;
        issue_s     = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        flush_s     = 1'b0;
        if (i_load_en) begin
            state_nxt_s = ST_LOAD;
            pc_nxt_s    = '0;
            flush_s     = 1'b1;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (i_start) begin
                        state_nxt_s = ST_RUN;
                        issue_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (i_branch_valid) begin
                        flush_s   = 1'b1;
                        issue_s   = 1'b1;
                        rd_addr_s = i_branch_dir;
                    end else begin
                        pop_s = !empty_s && !i_stall;
                        if (pop_s && (head_s[ENTRY_W-1 -: W] == HALT_WORD)) begin
                            flush_s     = 1'b1;
                            state_nxt_s = ST_HALTED;
                        end else begin
                            push_s  = inflight_r;
                            issue_s = (occ_s < (CNT_W+1)'(FIFO_DEPTH));
                        end
                    end
                end
                ST_HALTED: state_nxt_s = ST_HALTED;
                default:   state_nxt_s = ST_LOAD;
            endcase
            pc_nxt_s = issue_s ? (rd_addr_s + A'(1)) : pc_r;
        end
    end

    // Control registers: state, PC and the single outstanding read.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state_r    <= ST_LOAD;
            pc_r       <= '0;
            inflight_r <= 1'b0;
            rd_pc1_r   <= '0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            inflight_r <= issue_s;
            if (issue_s) rd_pc1_r <= rd_addr_s + A'(1);
        end
    end

    // Single-port program memory; contents survive reset and writes win over reads.
    always_ff @(posedge i_clock) begin
        if (i_load_en) begin
            mem_r[i_load_addr] <= i_load_data;
        end else if (issue_s) begin
            rd_data_r <= mem_r[rd_addr_s];
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk   (i_clock),
        .srst  (i_soft_reset),
        .flush (flush_s),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({rd_data_r, rd_pc1_r}),
        .rdata (head_s),
        .count (count_s),
        .empty (empty_s)
    );

    assign o_valid              = !empty_s;
    assign o_instruction        = empty_s ? NOP_WORD : head_s[ENTRY_W-1 -: W];
    assign o_direccion_adder_pc = empty_s ? '0 : head_s[A-1:0];
    assign o_contador_programa  = pc_r;
    assign o_halted             = (state_r == ST_HALTED);
    assign o_count              = count_s;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_fetch_prefetch_unit;

    localparam int D = 4;
    localparam logic [31:0] NOP_W  = 32'h0021_0824;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        soft_reset = 1'b1, load_en = 1'b0, start = 1'b0, stall = 1'b0, branch_valid = 1'b0;
    logic [10:0] load_addr = '0, branch_dir = '0;
    logic [31:0] load_data = '0;
    logic [31:0] instruction;
    logic        valid, halted;
    logic [10:0] adder_pc, pc;
    logic [2:0]  count;

    always #5 clock = ~clock;

    fetch_prefetch_unit #(.RAM_WIDTH_PROGRAMA(32), .CANT_BITS_ADDR(11), .FIFO_DEPTH(D)) dut (
        .i_clock(clock), .i_soft_reset(soft_reset), .i_load_en(load_en), .i_load_addr(load_addr),
        .i_load_data(load_data), .i_start(start), .i_stall(stall), .i_branch_valid(branch_valid),
        .i_branch_dir(branch_dir), .o_instruction(instruction), .o_valid(valid),
        .o_direccion_adder_pc(adder_pc), .o_contador_programa(pc), .o_halted(halted), .o_count(count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of {word, pc+1}, one outstanding read, a fetch pointer and a mode.
    typedef struct { logic [31:0] ins; logic [10:0] pc1; } entry_t;
    entry_t      mq[$];
    logic [31:0] mmem [2048];
    int          mst = 0;          // 0 load, 1 run, 2 halted
    logic [10:0] mpc = '0;
    bit          mfly = 1'b0;
    logic [10:0] mfly_addr = '0;

    task automatic model_check();
        logic [31:0] e_ins;
        logic [10:0] e_pc1;
        e_ins = NOP_W;
        e_pc1 = '0;
        if (mq.size() != 0) begin
            e_ins = mq[0].ins;
            e_pc1 = mq[0].pc1;
        end
        check("model_valid", valid, (mq.size() != 0));
        check("model_instruction", instruction, e_ins);
        check("model_adder_pc", adder_pc, e_pc1);
        check("model_pc", pc, mpc);
        check("model_halted", halted, (mst == 2));
        check("model_count", count, mq.size());
    endtask

    task automatic model_step();
        bit pop_now, room, halt_hit;
        if (soft_reset) begin
            mst = 0; mpc = '0; mq.delete(); mfly = 1'b0;
        end else if (load_en) begin
            mmem[load_addr] = load_data;
            mst = 0; mpc = '0; mq.delete(); mfly = 1'b0;
        end else if (mst == 0) begin
            if (start) begin
                mfly = 1'b1; mfly_addr = mpc; mpc = mpc + 11'd1; mst = 1;
            end
        end else if (mst == 1) begin
            if (branch_valid) begin
                mq.delete(); mfly = 1'b1; mfly_addr = branch_dir; mpc = branch_dir + 11'd1;
            end else begin
                pop_now  = (mq.size() > 0) && !stall;
                halt_hit = 1'b0;
                if (pop_now) halt_hit = (mq[0].ins == HALT_W);
                if (halt_hit) begin
                    mq.delete(); mfly = 1'b0; mst = 2;
                end else begin
                    room = (mq.size() + int'(mfly)) < D;
                    if (pop_now) void'(mq.pop_front());
                    if (mfly) mq.push_back('{ins: mmem[mfly_addr], pc1: mfly_addr + 11'd1});
                    if (room) begin
                        mfly_addr = mpc; mpc = mpc + 11'd1; mfly = 1'b1;
                    end else begin
                        mfly = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_check();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic ld, input logic [10:0] la, input logic [31:0] dat,
                         input logic st, input logic stl, input logic br, input logic [10:0] bd);
        soft_reset = rst; load_en = ld; load_addr = la; load_data = dat;
        start = st; stall = stl; branch_valid = br; branch_dir = bd;
        tick();
    endtask

    typedef struct {
        logic        start;
        logic        stall;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [2:0]  exp_count;
        logic [10:0] exp_pc;
    } vec_t;
    vec_t vecs[16];

    initial begin
        logic [31:0] w;
        int guard;

        // Start with stall held for 10 cycles, then release: words are i+1 at address i.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, NOP_W, 3'd0, 11'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, NOP_W, 3'd0, 11'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'd1, 3'd1, 11'd2};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'd1, 3'd2, 11'd3};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'd1, 3'd3, 11'd4};
        for (int i = 5; i < 10; i++) vecs[i] = '{1'b0, 1'b1, 1'b1, 32'd1, 3'd4, 11'd4};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'd1, 3'd4, 11'd4};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'd2, 3'd3, 11'd4};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'd3, 3'd2, 11'd5};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'd4, 3'd2, 11'd6};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'd5, 3'd2, 11'd7};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'd6, 3'd2, 11'd8};

        repeat (2) @(posedge clock);
        #1;
        check("reset_valid", valid, 1'b0);
        check("reset_instruction", instruction, NOP_W);
        check("reset_pc", pc, 11'd0);
        check("reset_count", count, 3'd0);
        check("reset_adder_pc", adder_pc, 11'd0);
        check("reset_halted", halted, 1'b0);

        for (int i = 0; i < 2048; i++) begin
            w = $urandom;
            if (w == HALT_W) w = 32'd0;
            drive(1'b0, 1'b1, 11'(i), w, 1'b0, 1'b0, 1'b0, 11'd0);
        end
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 11'(i), 32'(i + 1), 1'b0, 1'b0, 1'b0, 11'd0);

        for (int i = 0; i < 16; i++) begin
            soft_reset = 1'b0; load_en = 1'b0; branch_valid = 1'b0;
            start = vecs[i].start; stall = vecs[i].stall;
            check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_instr", i), instruction, vecs[i].exp_instr);
            check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            tick();
        end

        // Branch taken during a stall while three entries are queued.
        guard = 0;
        while (count != 3'd3 && guard < 20) begin
            drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b1, 1'b0, 11'd0);
            guard++;
        end
        check("pre_branch_count", count, 3'd3);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b1, 1'b1, 11'h100);
        check("branch_flush_count", count, 3'd0);
        check("branch_flush_valid", valid, 1'b0);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 11'd0);
        check("branch_target_instr", instruction, mmem[11'h100]);
        check("branch_target_valid", valid, 1'b1);
        check("branch_target_adder", adder_pc, 11'h101);

        // Address wrap from the top of memory.
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b1, 11'h7FE);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 11'd0);
        check("wrap0_instr", instruction, mmem[11'h7FE]);
        check("wrap0_adder", adder_pc, 11'h7FF);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 11'd0);
        check("wrap1_instr", instruction, mmem[11'h7FF]);
        check("wrap1_adder", adder_pc, 11'h000);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 11'd0);
        check("wrap2_instr", instruction, 32'd1);
        check("wrap2_adder", adder_pc, 11'h001);

        // HALT at address 3.
        drive(1'b0, 1'b1, 11'd3, HALT_W, 1'b0, 1'b0, 1'b0, 11'd0);
        check("load_valid", valid, 1'b0);
        check("load_pc", pc, 11'd0);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 11'd0);
            check($sformatf("halt_seq%0d", i), instruction, (i == 4) ? HALT_W : 32'(i));
        end
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 11'd0);
        check("halted_flag", halted, 1'b1);
        check("halted_valid", valid, 1'b0);
        check("halted_pc", pc, 11'd5);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 11'd0);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0);
        check("halted_pc_frozen", pc, 11'd5);
        check("halted_ignores_start", halted, 1'b1);
        drive(1'b0, 1'b1, 11'd3, 32'd4, 1'b0, 1'b0, 1'b0, 11'd0);
        check("unhalt_flag", halted, 1'b0);
        check("unhalt_pc", pc, 11'd0);

        // Reset together with a branch mid-run; memory must survive.
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0);
        repeat (4) drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 11'd0);
        drive(1'b1, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b1, 11'h055);
        check("rst_pc", pc, 11'd0);
        check("rst_count", count, 3'd0);
        check("rst_valid", valid, 1'b0);
        check("rst_instruction", instruction, NOP_W);
        check("rst_adder", adder_pc, 11'd0);
        check("rst_halted", halted, 1'b0);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 1'b0, 11'd0);
        check("rst_mem_kept", instruction, 32'd1);
        check("rst_mem_valid", valid, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            w = ($urandom_range(0, 9) == 0) ? HALT_W : $urandom;
            drive(($urandom_range(0, 999) < 5), ($urandom_range(0, 99) == 0), 11'($urandom), w,
                  ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0), 11'($urandom));
        end
        model_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
